multicycle_controller: RTL and testbench
========================================

// Module: multicycle_controller
// PURPOSE
//   Multicycle control FSM for the ARM-subset data_path. Decodes cond/op/funct/rd
//   from the latched instruction and holds the NZCV flag register. Sequences
//   fetch/decode/execute/writeback one step per clk, and stalls on a memory
//   ready handshake. All strobes are Moore outputs of the state, except where
//   noted as gated by mem_ready.
// PARAMETERS
//   MEM_WAIT_MAX  15  max cycles waiting for mem_ready before abort (1..255)
// PORTS
//   clk          in   1  rising-edge clock
//   reset        in   1  asynchronous, active-low reset
//   cond         in   4  instr[31:28]
//   op           in   2  instr[27:26]
//   funct        in   6  instr[25:20]; [5]=I, [4:1]=cmd, [0]=S/L
//   rd           in   4  instr[15:12]
//   alu_flags    in   4  NZCV from ALU, current cycle
//   mem_ready    in   1  memory completes the access this cycle
//   pc_write     out  1  load pc
//   ir_write     out  1  latch instr
//   adr_src      out  1  0=pc, 1=alu_result as memory address
//   mem_write    out  1  store strobe, held until mem_ready
//   reg_write    out  1  register file write enable
//   result_src   out  2  00=alu_out reg, 01=read_data, 10=alu_result
//   alu_src_a    out  2  00=rd1, 01=pc
//   alu_src_b    out  2  00=shifted rd2, 01=ext_imm, 10=const 4
//   imm_src      out  2  00=imm8, 01=imm12, 10=branch imm24<<2
//   reg_src      out  2  [0]=ra1 is r15, [1]=ra2 is rd (STR)
//   alu_control  out  3  000 ADD, 001 SUB, 010 AND, 011 ORR, 100 MOV(pass B)
//   mem_err      out  1  one-cycle pulse on mem_ready timeout
// BEHAVIOUR
//   Reset (reset=0): state=FETCH, flags=0, wait counter=0, all outputs 0,
//     mem_write dropped immediately. Reset is async and applies mid-access.
//   FETCH: adr_src=0, a=pc, b=4, result_src=10. While mem_ready=0, stay here
//     and count. On the mem_ready=1 cycle, pulse ir_write and pc_write, then go
//     to DECODE.
//   DECODE: a=pc, b=4 (forms pc+8). Compute cond_ex from flags:
//     EQ/NE/CS/CC/MI/PL/VS/VC/HI/LS/GE/LT/GT/LE/AL; 1111 counts as false.
//     If cond_ex=0, go to FETCH. Otherwise: op=01 -> MEMADR;
//     op=00 -> funct[5] ? EXECI : EXECR; op=10 -> BRANCH;
//     op=11 -> FETCH (NOP).
//   MEMADR: a=rd1, b=imm12, ADD. funct[0]=1 -> MEMRD, else MEMWR.
//   MEMRD: adr_src=1. Wait for mem_ready, then go to MEMWB.
//   MEMWR: adr_src=1, reg_src[1]=1, mem_write=1 until mem_ready, then FETCH.
//   MEMWB: result_src=01, then FETCH.
//   EXECR/EXECI: b = shifted rd2 (EXECR) or imm8 (EXECI). cmd decode:
//     0100 ADD, 0010 SUB, 0000 AND, 1100 ORR, 1101 MOV, 1010 CMP (SUB);
//     any other cmd runs as ADD. If S=1 or cmd=CMP, flags<=alu_flags at the
//     clk edge. Next state: CMP -> FETCH, else ALUWB.
//   ALUWB: result_src=00, then FETCH.
//   Writeback (MEMWB/ALUWB): rd!=15 -> reg_write=1; rd=15 -> pc_write=1 and
//     reg_write=0 (write to pc).
//   BRANCH: reg_src[0]=1, a=rd1(pc+8), b=imm24<<2, ADD, result_src=10,
//     pc_write=1, then FETCH.
//   Timeout: the wait counter clears on every state change. If it reaches
//     MEM_WAIT_MAX in FETCH/MEMRD/MEMWR with mem_ready still 0: pulse mem_err,
//     abort with no pc/ir/reg write, and go to FETCH. mem_ready=1 on the limit
//     cycle wins over the timeout.
//   Latency: data-proc 4 cycles, CMP 3, LDR 5, STR 4, branch 3, skipped 2
//     (all with zero wait states).
// CONFIGURATION
//   COND_EXEC_EN defined: conditional execution as above.
//   COND_EXEC_EN undefined: cond_ex=1 for every cond field; flags still updated.
// TESTING
//   ADD r1,r2,#5 (E2821005), mem_ready=1 -> 4 cycles; reg_write=1 only in ALUWB,
//     alu_control=000.
//   LDR with mem_ready low 3 cycles in MEMRD -> MEMRD held 4 cycles,
//     reg_write=1 one cycle after ready, result_src=01.
//   CMP r0,r0 (E1500000) then BNE (1AFFFFFE) -> flags Z=1; branch skipped
//     (DECODE->FETCH), no pc_write beyond fetch.
//   STR, mem_ready never rises, MEM_WAIT_MAX=15 -> mem_write high 15 cycles,
//     then mem_err pulse and FETCH.
//   ADD pc,... (rd=15) -> ALUWB pc_write=1, reg_write=0.
//   reset=0 during MEMWR -> mem_write=0 same cycle, FETCH, flags=0000.

Source files
------------

// File: rtl/multicycle_controller.sv
// Multicycle control FSM with NZCV flags and mem_ready wait/timeout.
// Define COND_EXEC_EN to honour the cond field; otherwise every instr runs.
module multicycle_controller #(
  parameter int MEM_WAIT_MAX = 15
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] cond,
  input  logic [1:0] op,
  input  logic [5:0] funct,
  input  logic [3:0] rd,
  input  logic [3:0] alu_flags,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       ir_write,
  output logic       adr_src,
  output logic       mem_write,
  output logic       reg_write,
  output logic [1:0] result_src,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] imm_src,
  output logic [1:0] reg_src,
  output logic [2:0] alu_control,
  output logic       mem_err
);

  typedef enum logic [3:0] {
    S_FETCH,
    S_DECODE,
    S_MEMADR,
    S_MEMRD,
    S_MEMWR,
    S_MEMWB,
    S_EXECR,
    S_EXECI,
    S_ALUWB,
    S_BRANCH
  } state_t;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_ORR = 3'b011;
  localparam logic [2:0] ALU_MOV = 3'b100;

  localparam logic [7:0] WAIT_LIM = 8'(MEM_WAIT_MAX - 1);

  state_t     state, next;
  logic [3:0] flags;
  logic [7:0] wait_cnt;
  logic       mem_err_q;
  logic       cond_ex;
  logic       is_wait;
  logic       timeout;
  logic       is_cmp;
  logic       is_exec;
  logic       flag_upd;
  logic [3:0] cmd;
  logic [2:0] dp_ctl;

  assign cmd      = funct[4:1];
  assign is_cmp   = (cmd == 4'b1010);
  assign is_exec  = (state == S_EXECR) || (state == S_EXECI);
  assign flag_upd = is_exec && (funct[0] || is_cmp);
  assign is_wait  = (state == S_FETCH) || (state == S_MEMRD) ||
                    (state == S_MEMWR);
  // The limit cycle is the MEM_WAIT_MAX-th cycle spent waiting.
  assign timeout  = is_wait && !mem_ready && (wait_cnt == WAIT_LIM);
  assign mem_err  = mem_err_q;

`ifdef COND_EXEC_EN
  logic n_f, z_f, c_f, v_f;
  assign {n_f, z_f, c_f, v_f} = flags;

  always_comb begin
    cond_ex = 1'b0;
    case (cond)
      4'b0000: cond_ex = z_f;
      4'b0001: cond_ex = !z_f;
      4'b0010: cond_ex = c_f;
      4'b0011: cond_ex = !c_f;
      4'b0100: cond_ex = n_f;
      4'b0101: cond_ex = !n_f;
      4'b0110: cond_ex = v_f;
      4'b0111: cond_ex = !v_f;
      4'b1000: cond_ex = c_f && !z_f;
      4'b1001: cond_ex = !c_f || z_f;
      4'b1010: cond_ex = (n_f == v_f);
      4'b1011: cond_ex = (n_f != v_f);
      4'b1100: cond_ex = !z_f && (n_f == v_f);
      4'b1101: cond_ex = z_f || (n_f != v_f);
      4'b1110: cond_ex = 1'b1;
      default: cond_ex = 1'b0;
    endcase
  end
`else
  logic unused_cond;
  assign unused_cond = ^{cond, flags};
  assign cond_ex     = 1'b1;
`endif

  always_comb begin
    dp_ctl = ALU_ADD;
    unique case (1'b1)
      (cmd == 4'b0010),
      (cmd == 4'b1010): dp_ctl = ALU_SUB;
      (cmd == 4'b0000): dp_ctl = ALU_AND;
      (cmd == 4'b1100): dp_ctl = ALU_ORR;
      (cmd == 4'b1101): dp_ctl = ALU_MOV;
      default:          dp_ctl = ALU_ADD;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= S_FETCH;
      flags     <= 4'b0000;
      wait_cnt  <= 8'd0;
      mem_err_q <= 1'b0;
    end else begin
      state     <= next;
      mem_err_q <= timeout;
      if (flag_upd)
        flags <= alu_flags;
      if ((next != state) || timeout)
        wait_cnt <= 8'd0;
      else if (is_wait)
        wait_cnt <= wait_cnt + 8'd1;
    end
  end

  always_comb begin
    next        = state;
    pc_write    = 1'b0;
    ir_write    = 1'b0;
    adr_src     = 1'b0;
    mem_write   = 1'b0;
    reg_write   = 1'b0;
    result_src  = 2'b00;
    alu_src_a   = 2'b00;
    alu_src_b   = 2'b00;
    imm_src     = 2'b00;
    reg_src     = 2'b00;
    alu_control = ALU_ADD;
    if (reset) begin
      unique case (state)
        S_FETCH: begin
          alu_src_a  = 2'b01;
          alu_src_b  = 2'b10;
          result_src = 2'b10;
          if (mem_ready) begin
            ir_write = 1'b1;
            pc_write = 1'b1;
            next     = S_DECODE;
          end
        end
        S_DECODE: begin
          alu_src_a = 2'b01;
          alu_src_b = 2'b10;
          if (!cond_ex)
            next = S_FETCH;
          else begin
            unique case (op)
              2'b01:   next = S_MEMADR;
              2'b00:   next = funct[5] ? S_EXECI : S_EXECR;
              2'b10:   next = S_BRANCH;
              default: next = S_FETCH;
            endcase
          end
        end
        S_MEMADR: begin
          alu_src_b = 2'b01;
          imm_src   = 2'b01;
          next      = funct[0] ? S_MEMRD : S_MEMWR;
        end
        S_MEMRD: begin
          adr_src = 1'b1;
          if (mem_ready)
            next = S_MEMWB;
          else if (timeout)
            next = S_FETCH;
        end
        S_MEMWR: begin
          adr_src   = 1'b1;
          reg_src   = 2'b10;
          mem_write = 1'b1;
          if (mem_ready || timeout)
            next = S_FETCH;
        end
        S_MEMWB: begin
          result_src = 2'b01;
          reg_write  = (rd != 4'hF);
          pc_write   = (rd == 4'hF);
          next       = S_FETCH;
        end
        S_EXECR, S_EXECI: begin
          alu_src_b   = (state == S_EXECI) ? 2'b01 : 2'b00;
          alu_control = dp_ctl;
          next        = is_cmp ? S_FETCH : S_ALUWB;
        end
        S_ALUWB: begin
          reg_write = (rd != 4'hF);
          pc_write  = (rd == 4'hF);
          next      = S_FETCH;
        end
        S_BRANCH: begin
          reg_src    = 2'b01;
          alu_src_b  = 2'b01;
          imm_src    = 2'b10;
          result_src = 2'b10;
          pc_write   = 1'b1;
          next       = S_FETCH;
        end
        default: next = S_FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_controller.sv
// Bench for multicycle_controller: directed cases plus random instruction
// streams checked against a per-instruction latency/strobe model.
module tb_multicycle_controller;

  localparam int MAX = 15;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [3:0] cond = 4'hE;
  logic [1:0] op = 2'b11;
  logic [5:0] funct = 6'd0;
  logic [3:0] rd = 4'd0;
  logic [3:0] alu_flags = 4'd0;
  logic       mem_ready = 1'b0;
  logic       pc_write, ir_write, adr_src, mem_write, reg_write;
  logic [1:0] result_src, alu_src_a, alu_src_b, imm_src, reg_src;
  logic [2:0] alu_control;
  logic       mem_err;

  int   n_checks = 0;
  int   n_fail = 0;
  logic [3:0] flags_m = 4'd0;
  logic err_pending = 1'b0;

  multicycle_controller #(.MEM_WAIT_MAX(MAX)) dut (
    .clk(clk), .reset(reset), .cond(cond), .op(op), .funct(funct),
    .rd(rd), .alu_flags(alu_flags), .mem_ready(mem_ready),
    .pc_write(pc_write), .ir_write(ir_write), .adr_src(adr_src),
    .mem_write(mem_write), .reg_write(reg_write),
    .result_src(result_src), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .imm_src(imm_src), .reg_src(reg_src),
    .alu_control(alu_control), .mem_err(mem_err)
  );

  always #5 clk = ~clk;

  function automatic logic [18:0] all_outs();
    return {pc_write, ir_write, adr_src, mem_write, reg_write,
            result_src, alu_src_a, alu_src_b, imm_src, reg_src,
            alu_control, mem_err};
  endfunction

  function automatic bit cond_ok(input logic [3:0] c, input logic [3:0] f);
    bit n, z, cy, v;
    {n, z, cy, v} = f;
    case (c)
      4'h0: return z;
      4'h1: return !z;
      4'h2: return cy;
      4'h3: return !cy;
      4'h4: return n;
      4'h5: return !n;
      4'h6: return v;
      4'h7: return !v;
      4'h8: return cy && !z;
      4'h9: return !cy || z;
      4'hA: return n == v;
      4'hB: return n != v;
      4'hC: return !z && (n == v);
      4'hD: return z || (n != v);
      4'hE: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [2:0] alu_of(input logic [3:0] c);
    case (c)
      4'b0100: return 3'b000;
      4'b0010: return 3'b001;
      4'b1010: return 3'b001;
      4'b0000: return 3'b010;
      4'b1100: return 3'b011;
      4'b1101: return 3'b100;
      default: return 3'b000;
    endcase
  endfunction

  task automatic run_instr(input logic [31:0] ins, input int fw,
                           input int w, input bit force_f,
                           input logic [3:0] ff);
    bit ex, is_mem, is_ld, is_st, is_dp, is_cmp, is_br, tmo, wb, upd;
    int mc, lat, ms, exp_pc, exp_rw, exp_mw;
    int n_ir, n_pc, n_rw, n_mw;
    logic [3:0] new_f;
    cond  = ins[31:28];
    op    = ins[27:26];
    funct = ins[25:20];
    rd    = ins[15:12];
`ifdef COND_EXEC_EN
    ex = cond_ok(cond, flags_m);
`else
    ex = 1'b1;
`endif
    is_mem = ex && (op == 2'b01);
    is_ld  = is_mem && funct[0];
    is_st  = is_mem && !funct[0];
    is_dp  = ex && (op == 2'b00);
    is_cmp = is_dp && (funct[4:1] == 4'b1010);
    is_br  = ex && (op == 2'b10);
    tmo    = is_mem && (w >= MAX);
    mc     = tmo ? MAX : w + 1;
    wb     = (is_dp && !is_cmp) || (is_ld && !tmo);
    upd    = is_dp && (funct[0] || is_cmp);
    if (!ex || op == 2'b11) lat = fw + 2;
    else if (is_br || is_cmp) lat = fw + 3;
    else if (is_dp) lat = fw + 4;
    else if (is_ld) lat = fw + 3 + mc + (tmo ? 0 : 1);
    else lat = fw + 3 + mc;
    ms     = fw + 3;
    exp_rw = (wb && rd != 4'hF) ? 1 : 0;
    exp_pc = 1 + (is_br ? 1 : 0) + ((wb && rd == 4'hF) ? 1 : 0);
    exp_mw = is_st ? mc : 0;
    n_ir = 0; n_pc = 0; n_rw = 0; n_mw = 0;
    new_f = flags_m;
    for (int c = 0; c < lat; c++) begin
      if (c <= fw) mem_ready = (c == fw);
      else if (is_mem && c >= ms) mem_ready = ((c - ms) == w);
      else mem_ready = 1'($urandom_range(0, 1));
      alu_flags = (force_f && c == fw + 2) ? ff : 4'($urandom);
      if (c == fw + 2 && upd) new_f = alu_flags;
      @(negedge clk);
      n_checks++;
      if (mem_err !== ((c == 0) ? err_pending : 1'b0)) begin
        n_fail++;
        $display("FAIL mem_err ins=%h cyc=%0d: got %b", ins, c, mem_err);
      end
      n_ir += int'(ir_write);
      n_pc += int'(pc_write);
      n_rw += int'(reg_write);
      n_mw += int'(mem_write);
      if (c == fw) begin
        n_checks++;
        if (ir_write !== 1'b1 || pc_write !== 1'b1) begin
          n_fail++;
          $display("FAIL fetch ins=%h: ir=%b pc=%b want 1 1",
                   ins, ir_write, pc_write);
        end
      end
      if (c == fw + 2 && is_dp) begin
        n_checks++;
        if (alu_control !== alu_of(funct[4:1]) ||
            alu_src_b !== (funct[5] ? 2'b01 : 2'b00)) begin
          n_fail++;
          $display("FAIL exec ins=%h: ctl=%b b=%b want %b %b", ins,
                   alu_control, alu_src_b, alu_of(funct[4:1]),
                   funct[5] ? 2'b01 : 2'b00);
        end
      end
      if (c == fw + 2 && is_br) begin
        n_checks++;
        if (reg_src !== 2'b01 || alu_src_b !== 2'b01 ||
            imm_src !== 2'b10) begin
          n_fail++;
          $display("FAIL branch ins=%h: rs=%b b=%b imm=%b want 01 01 10",
                   ins, reg_src, alu_src_b, imm_src);
        end
      end
      if (is_st && c == ms) begin
        n_checks++;
        if (adr_src !== 1'b1 || reg_src !== 2'b10) begin
          n_fail++;
          $display("FAIL store ins=%h: adr=%b rs=%b want 1 10",
                   ins, adr_src, reg_src);
        end
      end
      if (wb && c == lat - 1) begin
        n_checks++;
        if (result_src !== (is_ld ? 2'b01 : 2'b00) ||
            reg_write !== (rd != 4'hF) || pc_write !== (rd == 4'hF)) begin
          n_fail++;
          $display("FAIL wb ins=%h: res=%b rw=%b pc=%b", ins,
                   result_src, reg_write, pc_write);
        end
      end
      @(posedge clk);
      #1;
    end
    flags_m     = new_f;
    err_pending = tmo;
    n_checks++;
    if (n_ir != 1 || n_pc != exp_pc || n_rw != exp_rw || n_mw != exp_mw)
    begin
      n_fail++;
      $display("FAIL counts ins=%h: ir/pc/rw/mw=%0d/%0d/%0d/%0d want 1/%0d/%0d/%0d",
               ins, n_ir, n_pc, n_rw, n_mw, exp_pc, exp_rw, exp_mw);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    mem_ready = 1'b1;
    #3;
    n_checks++;
    if (all_outs() !== 19'd0) begin
      n_fail++;
      $display("FAIL reset_outs: got %h want 0", all_outs());
    end
    @(posedge clk);
    #1;
    n_checks++;
    if (all_outs() !== 19'd0) begin
      n_fail++;
      $display("FAIL reset_hold: got %h want 0", all_outs());
    end
    reset = 1'b1;
    flags_m = 4'd0;
    err_pending = 1'b0;
  endtask

  task automatic test_directed();
    run_instr(32'hE2821005, 0, 0, 1'b0, 4'd0);
    run_instr(32'hE5921000, 0, 3, 1'b0, 4'd0);
    run_instr(32'hE1500000, 0, 0, 1'b1, 4'b0100);
    run_instr(32'h1AFFFFFE, 0, 0, 1'b0, 4'd0);
    run_instr(32'hE5821000, 1, 100, 1'b0, 4'd0);
    run_instr(32'hE282F005, 0, 0, 1'b0, 4'd0);
    run_instr(32'hE5921000, 2, 40, 1'b0, 4'd0);
    run_instr(32'hE591F000, 0, 0, 1'b0, 4'd0);
  endtask

  task automatic test_fetch_timeout();
    int n_wr;
    n_wr = 0;
    for (int c = 0; c < MAX; c++) begin
      mem_ready = 1'b0;
      @(negedge clk);
      n_wr += int'(ir_write) + int'(pc_write) + int'(mem_err);
      @(posedge clk);
      #1;
    end
    n_checks++;
    if (n_wr != 0) begin
      n_fail++;
      $display("FAIL fetch_timeout_strobes: got %0d want 0", n_wr);
    end
    err_pending = 1'b1;
    run_instr(32'hE2821005, 0, 0, 1'b0, 4'd0);
  endtask

  task automatic test_reset_mid_store();
    run_instr(32'hE1500000, 0, 0, 1'b1, 4'b0100);
    cond = 4'hE; op = 2'b01; funct = 6'b011000; rd = 4'd1;
    for (int c = 0; c < 4; c++) begin
      mem_ready = (c == 0);
      @(posedge clk);
      #1;
    end
    @(negedge clk);
    n_checks++;
    if (mem_write !== 1'b1) begin
      n_fail++;
      $display("FAIL pre_reset_store: mem_write=%b want 1", mem_write);
    end
    #2 reset = 1'b0;
    #1;
    n_checks++;
    if (all_outs() !== 19'd0) begin
      n_fail++;
      $display("FAIL mid_reset_outs: got %h want 0", all_outs());
    end
    @(posedge clk);
    #1;
    reset = 1'b1;
    flags_m = 4'd0;
    err_pending = 1'b0;
    run_instr(32'h0A000004, 0, 0, 1'b0, 4'd0);
    run_instr(32'h1A000004, 0, 0, 1'b0, 4'd0);
  endtask

  task automatic test_random();
    logic [31:0] ins;
    int w;
    for (int i = 0; i < 80; i++) begin
      ins = $urandom;
      if ($urandom_range(0, 2) != 0) ins[31:28] = 4'hE;
      w = ($urandom_range(0, 7) == 0) ? MAX + 3 : $urandom_range(0, 4);
      run_instr(ins, $urandom_range(0, 2), w, 1'b0, 4'd0);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_fetch_timeout();
    test_reset_mid_store();
    test_random();
    run_instr(32'hE2821005, 0, 0, 1'b0, 4'd0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
